// File: rtl/counter_ift_param.sv
// Up/down counter with load, wrap/saturate mode and registered terminal count,
// carrying information-flow taint shadow state for every output register.
module counter_ift_param #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned TAINT_W  = 32,
   parameter bit          SATURATE = 1'b0
) (
   input  logic               clk,
   input  logic [TAINT_W-1:0] clk_t,
   input  logic               rst,
   input  logic [TAINT_W-1:0] rst_t,
   input  logic               en,
   input  logic [TAINT_W-1:0] en_t,
   input  logic               up,
   input  logic [TAINT_W-1:0] up_t,
   input  logic               load,
   input  logic [TAINT_W-1:0] load_t,
   input  logic [WIDTH-1:0]   load_val,
   input  logic [TAINT_W-1:0] load_val_t,
   output logic [WIDTH-1:0]   count,
   output logic [TAINT_W-1:0] count_t,
   output logic               tc,
   output logic [TAINT_W-1:0] tc_t
);

   localparam logic [WIDTH-1:0] Max = {WIDTH{1'b1}};

   logic [WIDTH-1:0]   count_q, count_d;
   logic               tc_q, tc_d;
   // Taint registers start clean; value registers stay undefined until reset.
   logic [TAINT_W-1:0] count_t_q = '0;
   logic [TAINT_W-1:0] tc_t_q    = '0;
   logic [TAINT_W-1:0] count_t_d, tc_t_d;

   logic [TAINT_W-1:0] dec_t;
   logic [TAINT_W-1:0] step_t;
   logic               boundary;

   // Clock taint is part of the uniform port list only.
   logic unused_clk_t;
   assign unused_clk_t = ^clk_t;

   assign dec_t    = rst_t | load_t | en_t;
   assign step_t   = count_t_q | dec_t | up_t;
   assign boundary = up ? (count_q == Max) : (count_q == '0);

   always_comb begin
      count_d   = count_q;
      count_t_d = count_t_q | dec_t;
      tc_d      = 1'b0;
      tc_t_d    = dec_t;
      if (load) begin
         count_d   = load_val;
         count_t_d = load_val_t | dec_t;
      end else if (en) begin
         if (!(SATURATE && boundary)) begin
            count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
         end
         count_t_d = step_t;
         tc_d      = boundary;
         tc_t_d    = step_t;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         count_t_q <= rst_t;
         tc_q      <= 1'b0;
         tc_t_q    <= rst_t;
      end else begin
         count_q   <= count_d;
         count_t_q <= count_t_d;
         tc_q      <= tc_d;
         tc_t_q    <= tc_t_d;
      end
   end

   assign count   = count_q;
   assign count_t = count_t_q;
   assign tc      = tc_q;
   assign tc_t    = tc_t_q;

endmodule
